// File: rtl/qproject_if.sv
// qproject_if: the dti valid/ready stream carrying a W-bit packed element.
//   valid : producer -> consumer, element present
//   ready : consumer -> producer, element taken when valid && ready
//   data  : producer -> consumer, packed element
interface qproject_if #(
  parameter int W = 8
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/qproject.sv
// qproject: registered queue-projection stage. Strips the DIN_LVL-DOUT_LVL
// innermost eot levels from a dti stream and re-emits a DOUT_LVL stream.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   din  : consumer, {cut_eot, out_eot, data}   (TDIN+DIN_LVL bits)
//   dout : producer, {out_eot, data}            (TDIN+DOUT_LVL bits)
// MODE 0 forwards all, 1 forwards the last element of each inner
// sub-transaction, 2 forwards its first data with the closing eot.
// SKID=1 adds a second entry so din.ready can be a flop.
module qproject #(
  parameter int TDIN     = 17,
  parameter int DIN_LVL  = 2,
  parameter int DOUT_LVL = 1,
  parameter int MODE     = 0,
  parameter int SKID     = 1
) (
  input  logic         clk,
  input  logic         rst,
  qproject_if.consumer din,
  qproject_if.producer dout
);

  localparam int CUT = DIN_LVL - DOUT_LVL;
  localparam int OW  = TDIN + DOUT_LVL;

  logic            close_s;
  logic            acc_s;
  logic            emit_s;
  logic            in_ready_s;
  logic            dout_hs_s;
  logic [OW-1:0]   emit_word_s;

  logic            first_q, first_d;
  logic [TDIN-1:0] hold_q,  hold_d;
  logic            main_v_q, main_v_d;
  logic [OW-1:0]   main_q,   main_d;
  logic            skid_v_q, skid_v_d;
  logic [OW-1:0]   skid_q,   skid_d;
  logic            rdy_q,    rdy_d;

  // With no levels to cut, every element closes its own inner transaction.
  generate
    if (CUT > 0) begin : g_cut
      assign close_s = &din.data[TDIN+DIN_LVL-1:OW];
    end else begin : g_nocut
      assign close_s = 1'b1;
    end
  endgenerate

  // rdy_q stays low through reset, so din.ready is 0 in reset for both
  // storage styles; with SKID=1 it also mirrors "skid entry empty".
  assign in_ready_s = (SKID != 0) ? rdy_q : (rdy_q && (!main_v_q || dout.ready));
  assign acc_s      = din.valid && in_ready_s;
  assign dout_hs_s  = main_v_q && dout.ready;

  // Selection: decide whether this accept emits and build the output word.
  always_comb begin
    emit_word_s = din.data[OW-1:0];
    emit_s      = 1'b0;
    first_d     = first_q;
    hold_d      = hold_q;
    case (MODE)
      1: emit_s = acc_s && close_s;
      2: begin
        emit_s = acc_s && close_s;
        // A non-first closing element carries the held first data.
        if (!first_q) begin
          emit_word_s[TDIN-1:0] = hold_q;
        end else begin
          emit_word_s = din.data[OW-1:0];
        end
        if (acc_s) begin
          first_d = close_s;
          if (first_q) begin
            hold_d = din.data[TDIN-1:0];
          end else begin
            hold_d = hold_q;
          end
        end else begin
          first_d = first_q;
        end
      end
      default: emit_s = acc_s;
    endcase
  end

  // Output storage: drain main, promote skid, then place any new element.
  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (dout_hs_s) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = 1'b0;
      end
    end else begin
      main_v_d = main_v_q;
    end
    if (emit_s) begin
      if (!main_v_d) begin
        main_d   = emit_word_s;
        main_v_d = 1'b1;
      end else if (SKID != 0) begin
        skid_d   = emit_word_s;
        skid_v_d = 1'b1;
      end else begin
        main_d   = main_q;
      end
    end else begin
      skid_d = skid_q;
    end
    rdy_d = (SKID != 0) ? !skid_v_d : 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q  <= 1'b1;
      hold_q   <= {TDIN{1'b0}};
      main_v_q <= 1'b0;
      main_q   <= {OW{1'b0}};
      skid_v_q <= 1'b0;
      skid_q   <= {OW{1'b0}};
      rdy_q    <= 1'b0;
    end else begin
      first_q  <= first_d;
      hold_q   <= hold_d;
      main_v_q <= main_v_d;
      main_q   <= main_d;
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
      rdy_q    <= rdy_d;
    end
  end

  assign din.ready  = in_ready_s;
  assign dout.valid = main_v_q;
  assign dout.data  = main_q;

endmodule

// File: tb/tb_qproject.sv
// tb_qproject: six qproject instances (MODE 0/1/2, SKID 0/1, one flat
// output) driven from shared tables, directed sequences and random traffic,
// all checked against a transaction-level model of inner sub-transactions.
module tb_qproject;

  localparam int N = 6;
  // Instances: 0 M0 S1, 1 M1 S1, 2 M2 S1, 3 M0 S0, 4 flat M1 S1, 5 M2 S0
  localparam logic [N-1:0][1:0] MODE_A = {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
  localparam logic [N-1:0]      SKID_A = 6'b010111;
  localparam logic [N-1:0]      FLAT_A = 6'b010000;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_v  [N];
  logic [9:0]  din_d  [N];
  logic        dout_r [N];
  logic        in_rdy [N];
  logic        out_v  [N];
  logic [31:0] out_d  [N];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: current inner transaction list and expected output FIFO.
  logic [7:0]  inner_buf [N][64];
  int          inner_cnt [N];
  logic [31:0] exp_mem   [N][16];
  int          exp_wr    [N];
  int          exp_rd    [N];
  logic        emit_prev [N];
  logic        stall_prev[N];
  logic [31:0] stall_d   [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int DL = FLAT_A[g] ? 1 : 2;
    localparam int OL = FLAT_A[g] ? 0 : 1;
    qproject_if #(.W(8 + DL)) din_if ();
    qproject_if #(.W(8 + OL)) dout_if ();
    assign din_if.valid  = din_v[g];
    assign din_if.data   = din_d[g][8+DL-1:0];
    assign dout_if.ready = dout_r[g];
    assign in_rdy[g]     = din_if.ready;
    assign out_v[g]      = dout_if.valid;
    assign out_d[g]      = 32'(dout_if.data);
    qproject #(
      .TDIN(8), .DIN_LVL(DL), .DOUT_LVL(OL),
      .MODE(int'(MODE_A[g])), .SKID(int'(SKID_A[g]))
    ) u_dut (
      .clk(clk), .rst(rst), .din(din_if.consumer), .dout(dout_if.producer)
    );
  end

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Append to the inner transaction; on its close, emit per mode.
  task automatic model_accept(input int i, output bit emitted);
    logic [9:0]  w;
    logic [7:0]  d;
    logic        oe;
    logic        cl;
    logic [31:0] ow;
    w  = din_d[i];
    d  = w[7:0];
    oe = FLAT_A[i] ? 1'b0 : w[8];
    cl = FLAT_A[i] ? w[8] : w[9];
    ow = 32'd0;
    if (inner_cnt[i] < 64) inner_buf[i][inner_cnt[i]] = d;
    inner_cnt[i]++;
    emitted = 1'b0;
    case (MODE_A[i])
      2'd0: begin emitted = 1'b1; ow = {23'd0, oe, d}; end
      2'd1: begin emitted = cl;   ow = {23'd0, oe, d}; end
      default: begin emitted = cl; ow = {23'd0, oe, inner_buf[i][0]}; end
    endcase
    if (cl) inner_cnt[i] = 0;
    if (emitted) begin
      exp_mem[i][exp_wr[i] % 16] = ow;
      exp_wr[i]++;
    end
  endtask

  // Scoreboard: sample every instance on the falling edge.
  always @(negedge clk) begin
    int pend;
    bit em;
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        exp_rd[i]     = exp_wr[i];
        inner_cnt[i]  = 0;
        emit_prev[i]  = 1'b0;
        stall_prev[i] = 1'b0;
      end else begin
        if (emit_prev[i])
          chk($sformatf("u%0d latency", i), out_v[i] == 1'b1, out_v[i], 1);
        if (stall_prev[i]) begin
          chk($sformatf("u%0d hold_valid", i), out_v[i] == 1'b1, out_v[i], 1);
          chk($sformatf("u%0d hold_data", i), out_d[i] == stall_d[i], out_d[i], stall_d[i]);
        end
        pend = exp_wr[i] - exp_rd[i];
        if (out_v[i]) begin
          chk($sformatf("u%0d orphan_valid", i), pend > 0, pend, 1);
          if (dout_r[i] && pend > 0) begin
            chk($sformatf("u%0d stream_data", i), out_d[i] == exp_mem[i][exp_rd[i] % 16],
                out_d[i], exp_mem[i][exp_rd[i] % 16]);
            exp_rd[i]++;
          end
        end
        stall_prev[i] = out_v[i] && !dout_r[i];
        stall_d[i]    = out_d[i];
        em = 1'b0;
        if (din_v[i] && in_rdy[i]) model_accept(i, em);
        emit_prev[i] = em;
      end
    end
  end

  typedef struct {
    logic       v;
    logic [9:0] d;
    logic       v0; logic [8:0] d0;
    logic       v1; logic [8:0] d1;
    logic       v2; logic [8:0] d2;
  } vec_t;

  vec_t tbl [6];

  task automatic drive_all(input logic v, input logic [9:0] d);
    for (int i = 0; i < N; i++) begin
      din_v[i] = v && !FLAT_A[i];
      din_d[i] = d;
    end
  endtask

  task automatic check_out(input int i, input logic ev, input logic [8:0] ed, input string tag);
    chk($sformatf("u%0d %s valid", i, tag), out_v[i] == ev, out_v[i], ev);
    if (ev) chk($sformatf("u%0d %s data", i, tag), out_d[i] == 32'(ed), out_d[i], ed);
  endtask

  initial begin
    int k;
    int acc0;
    logic r0;
    for (int i = 0; i < N; i++) begin
      din_v[i] = 1'b0; din_d[i] = 10'd0; dout_r[i] = 1'b1;
      inner_cnt[i] = 0; exp_wr[i] = 0; exp_rd[i] = 0;
      emit_prev[i] = 1'b0; stall_prev[i] = 1'b0; stall_d[i] = 32'd0;
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    #3;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d reset valid", i), out_v[i] == 1'b0, out_v[i], 0);
      chk($sformatf("u%0d reset ready", i), in_rdy[i] == 1'b0, in_rdy[i], 0);
      chk($sformatf("u%0d reset data", i), out_d[i] == 32'd0, out_d[i], 0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++)
      chk($sformatf("u%0d ready after release", i), in_rdy[i] == 1'b1, in_rdy[i], 1);

    // Stream S then a lone closing element; expectations per mode.
    tbl[0] = '{1'b1, 10'h011, 1'b1, 9'h011, 1'b0, 9'h000, 1'b0, 9'h000};
    tbl[1] = '{1'b1, 10'h222, 1'b1, 9'h022, 1'b1, 9'h022, 1'b1, 9'h011};
    tbl[2] = '{1'b1, 10'h033, 1'b1, 9'h033, 1'b0, 9'h000, 1'b0, 9'h000};
    tbl[3] = '{1'b1, 10'h344, 1'b1, 9'h144, 1'b1, 9'h144, 1'b1, 9'h133};
    tbl[4] = '{1'b1, 10'h355, 1'b1, 9'h155, 1'b1, 9'h155, 1'b1, 9'h155};
    tbl[5] = '{1'b0, 10'h000, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000};
    for (int r = 0; r < 6; r++) begin
      drive_all(tbl[r].v, tbl[r].d);
      @(posedge clk); #1;
      check_out(0, tbl[r].v0, tbl[r].d0, $sformatf("tbl%0d", r));
      check_out(3, tbl[r].v0, tbl[r].d0, $sformatf("tbl%0d", r));
      check_out(1, tbl[r].v1, tbl[r].d1, $sformatf("tbl%0d", r));
      check_out(2, tbl[r].v2, tbl[r].d2, $sformatf("tbl%0d", r));
      check_out(5, tbl[r].v2, tbl[r].d2, $sformatf("tbl%0d", r));
    end

    // Flat output, one cut level, last-of-inner.
    din_v[4] = 1'b1; din_d[4] = 10'h0AA;
    @(posedge clk); #1;
    check_out(4, 1'b0, 9'h000, "flat_a");
    din_d[4] = 10'h1BB;
    @(posedge clk); #1;
    check_out(4, 1'b1, 9'h0BB, "flat_b");
    din_v[4] = 1'b0;
    @(posedge clk); #1;
    check_out(4, 1'b0, 9'h000, "flat_c");

    // Skid fill: dout stalled 3 cycles with continuous din.valid.
    for (int i = 0; i < N; i++) dout_r[i] = 1'b0;
    k = 0; acc0 = 0;
    for (int c = 0; c < 3; c++) begin
      drive_all(1'b1, {2'b11, 8'(8'h60 + k)});
      r0 = in_rdy[0];
      @(posedge clk); #1;
      if (r0) begin acc0++; k++; end
    end
    chk("skid accepted", acc0 == 2, acc0, 2);
    chk("skid full ready", in_rdy[0] == 1'b0, in_rdy[0], 0);
    for (int i = 0; i < N; i++) dout_r[i] = 1'b1;
    drive_all(1'b1, {2'b11, 8'(8'h60 + k)});
    @(posedge clk); #1;
    chk("skid ready back", in_rdy[0] == 1'b1, in_rdy[0], 1);
    for (int c = 0; c < 5; c++) begin
      drive_all(1'b1, {2'b11, 8'(8'h60 + k)});
      r0 = in_rdy[0];
      @(posedge clk); #1;
      if (r0) k++;
    end
    drive_all(1'b0, 10'h000);
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of an inner transaction.
    drive_all(1'b1, 10'h033);
    @(posedge clk); #1;
    drive_all(1'b0, 10'h000);
    #2 rst = 1'b0;
    #1;
    chk("midrst valid", out_v[2] == 1'b0, out_v[2], 0);
    chk("midrst ready", in_rdy[2] == 1'b0, in_rdy[2], 0);
    chk("midrst u0 valid", out_v[0] == 1'b0, out_v[0], 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    drive_all(1'b1, 10'h355);
    @(posedge clk); #1;
    check_out(2, 1'b1, 9'h155, "after_rst");
    check_out(5, 1'b1, 9'h155, "after_rst");
    drive_all(1'b0, 10'h000);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        din_v[i]  = ($urandom_range(0, 3) != 0);
        din_d[i]  = 10'($urandom);
        dout_r[i] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < N; i++) begin
      din_v[i] = 1'b0; dout_r[i] = 1'b1;
    end
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      chk($sformatf("u%0d drained", i), exp_wr[i] == exp_rd[i], exp_wr[i] - exp_rd[i], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
